// File: rtl/mul_seq64.sv
// mul_seq64: iterative radix-2 shift-add multiplier producing a 2*WIDTH-bit product.
// Revision 1.0 - initial release.
`default_nettype none

module mul_seq64 #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] prod_lo,
   output logic [WIDTH-1:0] prod_hi
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic                 neg_q, neg_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;

   logic [WIDTH-1:0]     mag_a, mag_b;
   logic [2*WIDTH-1:0]   partial;

   assign mag_a   = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
   assign mag_b   = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
   assign partial = {{WIDTH{1'b0}}, mcand_q} << cnt_q;

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      neg_d    = neg_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      prod_d   = prod_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_RUN;
               mcand_d  = mag_a;
               mplier_d = mag_b;
               neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
               acc_d    = '0;
               cnt_d    = '0;
            end
         end
         S_RUN: begin
            if (mplier_q[0]) begin
               acc_d = acc_q + partial;
            end
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            // The trailing step (multiplier already exhausted) registers the
            // sign-corrected product so done lands WIDTH+1 edges after acceptance.
            if (cnt_q == LAST_CNT) begin
               state_d = S_FIN;
               prod_d  = neg_q ? (~acc_d + 1'b1) : acc_d;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         neg_q    <= 1'b0;
         acc_q    <= '0;
         cnt_q    <= '0;
         prod_q   <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         neg_q    <= neg_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
      end
   end

   assign busy    = (state_q != S_IDLE);
   assign done    = (state_q == S_FIN);
   assign prod_lo = prod_q[WIDTH-1:0];
   assign prod_hi = prod_q[2*WIDTH-1:WIDTH];

endmodule

`default_nettype wire

// File: tb/tb_mul_seq64.sv
// tb_mul_seq64: self-checking bench for mul_seq64 against an arithmetic reference model.
// Revision 1.0 - initial release.
`default_nettype none

module tb_mul_seq64;

   localparam int W = 64;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic          is_signed;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          busy;
   logic          done;
   logic [W-1:0]  prod_lo;
   logic [W-1:0]  prod_hi;

   int n_checks = 0;
   int n_fail   = 0;

   mul_seq64 #(.WIDTH(W), .CNT_W(7)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .is_signed (is_signed),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .prod_lo   (prod_lo),
      .prod_hi   (prod_hi)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] ref_mul(input logic [63:0] x, input logic [63:0] y,
                                             input logic s);
      logic signed [127:0] sx, sy;
      logic [127:0] ux, uy;
      if (s) begin
         sx = {{64{x[63]}}, x};
         sy = {{64{y[63]}}, y};
         return 128'(sx * sy);
      end
      ux = {64'd0, x};
      uy = {64'd0, y};
      return ux * uy;
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // Accepts one operation, scrambles the operand inputs while it runs and
   // reports how many edges after acceptance done was first observed (-1 = timeout).
   task automatic run_op(input logic [63:0] x, input logic [63:0] y, input logic s,
                         output logic [127:0] p, output int lat, output logic busy1);
      @(negedge clk);
      start = 1'b1; a = x; b = y; is_signed = s;
      @(negedge clk);
      start = 1'b0;
      busy1 = busy;
      lat   = -1;
      p     = '0;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         a = rnd64(); b = rnd64(); is_signed = 1'($urandom);
         if (done) begin
            lat = k;
            p   = {prod_hi, prod_lo};
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({busy, done} !== 2'b00 || {prod_hi, prod_lo} !== 128'd0) begin
         n_fail++;
         $display("FAIL reset_state: busy=%b done=%b prod=%h required busy=0 done=0 prod=0",
                  busy, done, {prod_hi, prod_lo});
      end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_unsigned_basic();
      logic [127:0] p; int lat; logic b1;
      run_op(64'd3, 64'd5, 1'b0, p, lat, b1);
      n_checks++;
      if (b1 !== 1'b1) begin
         n_fail++; $display("FAIL basic_busy: busy=%b required 1", b1);
      end
      n_checks++;
      if (lat !== 65) begin
         n_fail++; $display("FAIL basic_latency: edges=%0d required 65", lat);
      end
      n_checks++;
      if (p !== 128'd15) begin
         n_fail++; $display("FAIL basic_product: got %h required %h", p, 128'd15);
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++; $display("FAIL basic_after_done: busy=%b done=%b required 0 0", busy, done);
      end
   endtask

   task automatic test_signed_mixed();
      logic [127:0] p; int lat; logic b1;
      run_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd6, 1'b1, p, lat, b1);
      n_checks++;
      if (p !== {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFD6} || lat !== 65) begin
         n_fail++;
         $display("FAIL signed_mixed: got %h lat=%0d required ffffffffffffffffffffffffffffffd6 lat=65",
                  p, lat);
      end
   endtask

   task automatic test_extremes();
      logic [127:0] p; int lat; logic b1;
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, p, lat, b1);
      n_checks++;
      if (p !== {64'hFFFF_FFFF_FFFF_FFFE, 64'd1}) begin
         n_fail++; $display("FAIL ext_unsigned_max: got %h required fffffffffffffffe0000000000000001", p);
      end
      run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, p, lat, b1);
      n_checks++;
      if (p !== {64'h4000_0000_0000_0000, 64'd0}) begin
         n_fail++; $display("FAIL ext_signed_min: got %h required 40000000000000000000000000000000", p);
      end
   endtask

   task automatic test_ignore_busy();
      int n_done = 0; int first = -1; logic [127:0] p = '0, p2; int lat; logic b1;
      @(negedge clk);
      start = 1'b1; a = 64'd2; b = 64'd2; is_signed = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 150; k++) begin
         @(negedge clk);
         start = (k == 10 || k == 64);
         a = 64'd9; b = 64'd9;
         if (done) begin
            n_done++;
            if (first < 0) begin first = k; p = {prod_hi, prod_lo}; end
         end
      end
      start = 1'b0;
      n_checks++;
      if (n_done !== 1 || first !== 65) begin
         n_fail++; $display("FAIL busy_ignore_done: count=%0d first=%0d required count=1 first=65",
                            n_done, first);
      end
      n_checks++;
      if (p !== 128'd4) begin
         n_fail++; $display("FAIL busy_ignore_product: got %h required 4", p);
      end
      run_op(64'd9, 64'd9, 1'b0, p2, lat, b1);
      n_checks++;
      if (p2 !== 128'd81 || lat !== 65) begin
         n_fail++; $display("FAIL busy_new_start: got %h lat=%0d required 81 lat=65", p2, lat);
      end
   endtask

   task automatic test_reset_mid();
      int n_bad = 0; logic [127:0] p; int lat; logic b1;
      @(negedge clk);
      start = 1'b1; a = 64'd100; b = 64'd100; is_signed = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (29) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, done} !== 2'b00 || {prod_hi, prod_lo} !== 128'd0) begin
         n_fail++; $display("FAIL reset_mid_clear: busy=%b done=%b prod=%h required 0 0 0",
                            busy, done, {prod_hi, prod_lo});
      end
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (done || busy) n_bad++;
      end
      n_checks++;
      if (n_bad !== 0) begin
         n_fail++; $display("FAIL reset_mid_no_done: active cycles=%0d required 0", n_bad);
      end
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, p, lat, b1);
      n_checks++;
      if (p !== 128'd1 || lat !== 65) begin
         n_fail++; $display("FAIL reset_mid_fresh: got %h lat=%0d required 1 lat=65", p, lat);
      end
   endtask

   task automatic test_hold();
      int n_bad = 0; logic [127:0] p; int lat; logic b1;
      run_op(64'd3, 64'd5, 1'b0, p, lat, b1);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done !== 1'b0 || prod_lo !== 64'd15 || prod_hi !== 64'd0) n_bad++;
      end
      n_checks++;
      if (n_bad !== 0) begin
         n_fail++; $display("FAIL hold_idle: bad cycles=%0d required 0 (prod_lo=%h)", n_bad, prod_lo);
      end
      // Next operation must not expose partial sums before its done.
      n_bad = 0;
      @(negedge clk);
      start = 1'b1; a = 64'd0; b = 64'hFFFF_FFFF_FFFF_FFFB; is_signed = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k < 65; k++) begin
         @(negedge clk);
         if (prod_lo !== 64'd15 || prod_hi !== 64'd0) n_bad++;
      end
      n_checks++;
      if (n_bad !== 0) begin
         n_fail++; $display("FAIL hold_run: bad cycles=%0d required 0", n_bad);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b1 || {prod_hi, prod_lo} !== 128'd0) begin
         n_fail++; $display("FAIL signed_zero: done=%b prod=%h required done=1 prod=0",
                            done, {prod_hi, prod_lo});
      end
   endtask

   task automatic test_random();
      logic [127:0] p, exp_p; int lat; logic b1;
      logic [63:0] x, y; logic s;
      for (int i = 0; i < 24; i++) begin
         x = rnd64(); y = rnd64(); s = 1'($urandom);
         case ($urandom_range(0, 5))
            0: x = 64'h8000_0000_0000_0000;
            1: y = 64'hFFFF_FFFF_FFFF_FFFF;
            2: x = {32'd0, $urandom};
            default: ;
         endcase
         exp_p = ref_mul(x, y, s);
         run_op(x, y, s, p, lat, b1);
         n_checks++;
         if (p !== exp_p || lat !== 65) begin
            n_fail++; $display("FAIL random_%0d: a=%h b=%h s=%b got %h lat=%0d required %h lat=65",
                               i, x, y, s, p, lat, exp_p);
         end
      end
   endtask

   initial begin
      test_reset();
      test_unsigned_basic();
      test_signed_mixed();
      test_extremes();
      test_ignore_busy();
      test_reset_mid();
      test_hold();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
